// File: rtl/div_pkg.sv
// Shared types for the divider result path.
//   div_status_t : record status tag (OK / DIV0 / OVF)
//   div_rec_t    : {quot, rem, status} at the default divider widths
//   coll_state_e : collector FSM state
package div_pkg;

  localparam int unsigned DIV_QW = 5;
  localparam int unsigned DIV_RW = 5;

  typedef enum logic [1:0] {
    OK   = 2'b00,
    DIV0 = 2'b01,
    OVF  = 2'b10
  } div_status_t;

  typedef struct packed {
    logic [DIV_QW-1:0] quot;
    logic [DIV_RW-1:0] rem;
    div_status_t       status;
  } div_rec_t;

  typedef enum logic [0:0] {
    StIdle,
    StWaitR
  } coll_state_e;

endpackage

// File: rtl/div_result_fifo.sv
// First-word fall-through synchronous FIFO for divider result records.
//   clk_i / rst_ni : clock, synchronous active-low reset
//   push_i, data_i : write request and record; ignored when full unless popping
//   pop_i          : consume the head; ignored when empty
//   full_o/empty_o : occupancy flags
//   head_o         : head record, zero while empty
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module div_result_fifo
  import div_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = $bits(div_rec_t)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    // Masked while empty so the head reads zero after reset and after draining.
    head_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observable through the masked head.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/div_result_collector.sv
// Collects quotient/remainder pairs from the restoring divider's shared result bus
// and turns divide-by-zero / overflow terminations into status-tagged records.
// Completed records are buffered in a FIFO and offered over valid/ready.
//   clk, rst (sync, active-low)
//   div_data, doneq, donew, div_by0, ov : divider result bus and strobes
//   res_valid/res_ready, res_quot, res_rem, res_status : record output handshake
//   fifo_full, proto_err (sticky), drop (sticky)
// Build option: define DIV_COLLECT_DROPCNT_EN to add drop_cnt[7:0], a saturating
// count of records lost to a full FIFO.
module div_result_collector
  import div_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned QW    = DIV_QW,
  parameter int unsigned RW    = DIV_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [QW-1:0] div_data,
  input  logic          doneq,
  input  logic          donew,
  input  logic          div_by0,
  input  logic          ov,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [QW-1:0] res_quot,
  output logic [RW-1:0] res_rem,
  output logic [1:0]    res_status,
  output logic          fifo_full,
  output logic          proto_err,
  output logic          drop
`ifdef DIV_COLLECT_DROPCNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  // Record layout follows the instance widths; matches div_rec_t at the defaults.
  typedef struct packed {
    logic [QW-1:0] quot;
    logic [RW-1:0] rem;
    div_status_t   status;
  } rec_t;

  localparam int unsigned RecW = $bits(rec_t);

  coll_state_e     state_q, state_d;
  logic [QW-1:0]   quot_q, quot_d;
  logic            proto_err_q, proto_err_d;
  logic            drop_q, drop_d;
  logic            proto_set;
  logic            push_req, push, pop, drop_evt;
  logic            fifo_empty;
  rec_t            push_rec, head_rec;
  logic [RecW-1:0] head_raw;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      quot_q      <= '0;
      proto_err_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      quot_q      <= quot_d;
      proto_err_q <= proto_err_d;
      drop_q      <= drop_d;
    end
  end

  // Next state; priority div_by0 > ov > donew > doneq
  always_comb begin
    state_d = state_q;
    if (div_by0 || ov) begin
      state_d = StIdle;
    end else if (donew) begin
      if (state_q == StWaitR) begin
        state_d = StIdle;
      end else begin
        // donew with doneq in IDLE still captures the quotient
        state_d = doneq ? StWaitR : StIdle;
      end
    end else if (doneq) begin
      state_d = StWaitR;
    end
  end

  // FSM outputs: record push request, quotient latch, protocol error
  always_comb begin
    push_req  = 1'b0;
    push_rec  = '0;
    quot_d    = quot_q;
    proto_set = 1'b0;
    if (div_by0) begin
      push_req        = 1'b1;
      push_rec.status = DIV0;
      quot_d          = '0;
    end else if (ov) begin
      push_req        = 1'b1;
      push_rec.status = OVF;
      quot_d          = '0;
    end else if (donew) begin
      if (state_q == StWaitR) begin
        push_req        = 1'b1;
        push_rec.quot   = quot_q;
        push_rec.rem    = RW'(div_data);
        push_rec.status = OK;
      end else begin
        proto_set = 1'b1;
        if (doneq) begin
          quot_d = div_data;
        end
      end
    end else if (doneq) begin
      quot_d    = div_data;
      proto_set = (state_q == StWaitR);
    end
  end

  always_comb begin
    pop         = res_valid && res_ready;
    push        = push_req && (!fifo_full || pop);
    drop_evt    = push_req && fifo_full && !pop;
    proto_err_d = proto_err_q | proto_set;
    drop_d      = drop_q | drop_evt;
  end

  div_result_fifo #(
    .Depth (DEPTH),
    .Width (RecW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_raw)
  );

  always_comb begin
    head_rec   = rec_t'(head_raw);
    res_valid  = !fifo_empty;
    res_quot   = head_rec.quot;
    res_rem    = head_rec.rem;
    res_status = head_rec.status;
    proto_err  = proto_err_q;
    drop       = drop_q;
  end

`ifdef DIV_COLLECT_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_evt && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_div_result_collector.sv
module tb_div_result_collector;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_DIV0 = 2'b01;
  localparam logic [1:0] ST_OVF  = 2'b10;

  typedef struct packed {
    logic [4:0] q;
    logic [4:0] r;
    logic [1:0] s;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] div_data;
  logic       doneq, donew, div_by0, ov;
  logic       res_valid, res_ready;
  logic [4:0] res_quot, res_rem;
  logic [1:0] res_status;
  logic       fifo_full, proto_err, drop;
`ifdef DIV_COLLECT_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  div_result_collector #(
    .DEPTH (4),
    .QW    (5),
    .RW    (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .div_data   (div_data),
    .doneq      (doneq),
    .donew      (donew),
    .div_by0    (div_by0),
    .ov         (ov),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_quot   (res_quot),
    .res_rem    (res_rem),
    .res_status (res_status),
    .fifo_full  (fifo_full),
    .proto_err  (proto_err),
    .drop       (drop)
`ifdef DIV_COLLECT_DROPCNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the scoreboard front.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_record", {20'd0, res_quot, res_rem, res_status}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("record", {20'd0, res_quot, res_rem, res_status}, {20'd0, e});
      end
    end
  end

  // Drive strobes for exactly one active edge; returns at edge + 1.
  task automatic pulse(input logic q, input logic w, input logic z, input logic o,
                       input logic [4:0] d);
    doneq    = q;
    donew    = w;
    div_by0  = z;
    ov       = o;
    div_data = d;
    @(posedge clk);
    #1;
    doneq    = 1'b0;
    donew    = 1'b0;
    div_by0  = 1'b0;
    ov       = 1'b0;
    div_data = 5'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    res_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_drained"}, sb.size(), 0);
    check({name, "_valid_after"}, {31'd0, res_valid}, 0);
  endtask

  initial begin
    logic [4:0] qv [4];
    logic [4:0] rv [4];
    qv = '{5'd3, 5'd4, 5'd5, 5'd6};
    rv = '{5'd1, 5'd2, 5'd0, 5'd7};

    rst = 1'b0; res_ready = 1'b0; div_data = 5'd0;
    doneq = 1'b0; donew = 1'b0; div_by0 = 1'b0; ov = 1'b0;
    idle(2);
    check("rst_valid", {31'd0, res_valid}, 0);
    check("rst_quot", {27'd0, res_quot}, 0);
    check("rst_rem", {27'd0, res_rem}, 0);
    check("rst_status", {30'd0, res_status}, 0);
    check("rst_full", {31'd0, fifo_full}, 0);
    check("rst_proto", {31'd0, proto_err}, 0);
    check("rst_drop", {31'd0, drop}, 0);
`ifdef DIV_COLLECT_DROPCNT_EN
    check("rst_drop_cnt", {24'd0, drop_cnt}, 0);
`endif
    rst = 1'b1;

    // 100 / 7 = 14 r 2
    pulse(1, 0, 0, 0, 5'd14);
    idle(1);
    check("div_valid_before", {31'd0, res_valid}, 0);
    sb.push_back('{5'd14, 5'd2, ST_OK});
    pulse(0, 1, 0, 0, 5'd2);
    check("div_valid_latency", {31'd0, res_valid}, 1);
    res_ready = 1'b1;
    drain("div");
    check("div_proto", {31'd0, proto_err}, 0);

    // div_by0 while a quotient is pending
    pulse(1, 0, 0, 0, 5'd9);
    sb.push_back('{5'd0, 5'd0, ST_DIV0});
    pulse(0, 0, 1, 0, 5'd0);
    drain("div0");
    check("div0_proto", {31'd0, proto_err}, 0);

    // ov and div_by0 together -> DIV0 only
    sb.push_back('{5'd0, 5'd0, ST_DIV0});
    pulse(0, 0, 1, 1, 5'd0);
    drain("ov_div0");

    // ov alone, with a donew losing on priority
    sb.push_back('{5'd0, 5'd0, ST_OVF});
    pulse(0, 1, 0, 1, 5'd17);
    drain("ovf");
    check("ovf_proto", {31'd0, proto_err}, 0);

    // Fill the FIFO with consumer stalled
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse(1, 0, 0, 0, qv[i]);
      sb.push_back('{qv[i], rv[i], ST_OK});
      pulse(0, 1, 0, 0, rv[i]);
    end
    check("fill_full", {31'd0, fifo_full}, 1);
    check("fill_head_quot", {27'd0, res_quot}, {27'd0, qv[0]});

    // Push and pop in the same cycle while full
    pulse(1, 0, 0, 0, 5'd11);
    res_ready = 1'b1;
    sb.push_back('{5'd11, 5'd12, ST_OK});
    pulse(0, 1, 0, 0, 5'd12);
    res_ready = 1'b0;
    check("pushpop_full", {31'd0, fifo_full}, 1);
    check("pushpop_drop", {31'd0, drop}, 0);
    check("pushpop_head", {27'd0, res_quot}, {27'd0, qv[1]});

    // Push into a full FIFO with no pop -> dropped
    pulse(1, 0, 0, 0, 5'd20);
    pulse(0, 1, 0, 0, 5'd21);
    check("drop_flag", {31'd0, drop}, 1);
    check("drop_full", {31'd0, fifo_full}, 1);
`ifdef DIV_COLLECT_DROPCNT_EN
    check("drop_cnt", {24'd0, drop_cnt}, 1);
`endif
    check("drop_head_stable", {27'd0, res_quot}, {27'd0, qv[1]});
    res_ready = 1'b1;
    drain("fill");
    check("drop_sticky", {31'd0, drop}, 1);

    // Reset mid-operation discards entries and pending quotient
    res_ready = 1'b0;
    pulse(1, 0, 0, 0, 5'd1);
    pulse(0, 1, 0, 0, 5'd2);
    pulse(1, 0, 0, 0, 5'd3);
    do_reset();
    check("midrst_valid", {31'd0, res_valid}, 0);
    check("midrst_drop", {31'd0, drop}, 0);
    res_ready = 1'b1;
    pulse(0, 1, 0, 0, 5'd4);
    idle(1);
    check("idle_donew_proto", {31'd0, proto_err}, 1);
    check("idle_donew_valid", {31'd0, res_valid}, 0);
    do_reset();
    check("rst_clears_proto", {31'd0, proto_err}, 0);
    check("rst_empty", {31'd0, res_valid}, 0);

    // doneq twice in WAIT_R overwrites the quotient
    res_ready = 1'b1;
    pulse(1, 0, 0, 0, 5'd3);
    pulse(1, 0, 0, 0, 5'd4);
    check("overwrite_proto", {31'd0, proto_err}, 1);
    sb.push_back('{5'd4, 5'd1, ST_OK});
    pulse(0, 1, 0, 0, 5'd1);
    drain("overwrite");

    // Both strobes in WAIT_R: donew wins, no protocol error
    do_reset();
    res_ready = 1'b1;
    pulse(1, 0, 0, 0, 5'd7);
    sb.push_back('{5'd7, 5'd8, ST_OK});
    pulse(1, 1, 0, 0, 5'd8);
    drain("both_waitr");
    check("both_waitr_proto", {31'd0, proto_err}, 0);

    // Both strobes in IDLE: capture quotient, flag error
    pulse(1, 1, 0, 0, 5'd6);
    check("both_idle_proto", {31'd0, proto_err}, 1);
    check("both_idle_valid", {31'd0, res_valid}, 0);
    sb.push_back('{5'd6, 5'd5, ST_OK});
    pulse(0, 1, 0, 0, 5'd5);
    drain("both_idle");

    idle(2);
    check("sb_empty_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/div_result_collector.md
# div_result_collector

Downstream stage of the restoring divider. Samples the divider's shared 5-bit result bus on its `doneq` / `donew` strobes and pairs quotient with remainder. Also turns `DivBy0` / `OV` terminations into status-tagged records. Buffers completed records in a small FIFO and presents them to the consumer over a valid/ready handshake.

## Interface

**Parameters**
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `QW`, 5: quotient width; equals divider `data_out` width.
- `RW`, 5: remainder width; equals divider `data_out` width.

**Ports**
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `div_data` input QW: divider `data_out` bus.
- `doneq` input 1: one-cycle strobe; `div_data` holds the quotient.
- `donew` input 1: one-cycle strobe; `div_data` holds the remainder.
- `div_by0` input 1: one-cycle strobe; divide-by-zero termination.
- `ov` input 1: one-cycle strobe; quotient overflow termination.
- `res_valid` output 1: FIFO head is valid.
- `res_ready` input 1: consumer accepts the head.
- `res_quot` output QW: head quotient.
- `res_rem` output RW: head remainder.
- `res_status` output 2: head status: `OK`=00, `DIV0`=01, `OVF`=10.
- `fifo_full` output 1: FIFO holds DEPTH entries.
- `proto_err` output 1: sticky protocol-violation flag.
- `drop` output 1: sticky flag; a record was lost because the FIFO was full.

## Operation

- **FSM**
  - IDLE
    - `doneq` → latch quotient; go to WAIT_R.
    - `donew` alone → ignored; set `proto_err`.
  - WAIT_R
    - `donew` → push {quot, `div_data`, OK}; go to IDLE.
    - `doneq` → overwrite the latched quotient; set `proto_err`; stay in WAIT_R.
- **Terminations**, any state
  - `div_by0` → push {0, 0, DIV0}; go to IDLE; discard any latched quotient.
  - `ov` → push {0, 0, OVF}; go to IDLE; discard any latched quotient.
- **Priority in one cycle:** `div_by0` > `ov` > `donew` > `doneq`.
  - Lower-priority strobes are ignored.
  - Ignoring a `donew` or `doneq` because a termination won does not set `proto_err`.
- **Both strobes in IDLE:** `doneq` and `donew` together in IDLE → capture the quotient; go to WAIT_R; set `proto_err`.
- **FIFO**
  - First-word fall-through; `res_valid` = not empty.
  - Head fields stay stable while `res_valid && !res_ready`.
- **Pop:** occurs on `res_valid && res_ready`.
- **Full:** a push when full drops the record and sets `drop`; FIFO contents are unchanged.
- **Full with simultaneous pop:** push and pop in the same cycle while full → both succeed; count is unchanged.
- **Pointers:** log2(DEPTH)+1 bits; they wrap modulo 2·DEPTH; full/empty are decided by the MSB comparison.
- **Sticky clearing:** `proto_err` and `drop` clear only on reset.

## Timing

- **Reset values**, on a clock edge with `rst`=0:
  - State IDLE; FIFO empty.
  - `res_valid`=0, `res_quot`=0, `res_rem`=0, `res_status`=00.
  - `fifo_full`=0, `proto_err`=0, `drop`=0.
- **Reset mid-operation:** a pending quotient and all stored entries are discarded.
- **Latency:**
  - The strobe edge that pushes writes the FIFO.
  - `res_valid` rises in the next cycle (1-cycle latency into an empty FIFO).
- **Throughput:** one push and one pop per cycle.
- **Strobe sampling:** strobes are sampled only on the clock edge; a strobe held more than one cycle counts as repeated events.

## Configuration

- `DIV_COLLECT_DROPCNT_EN` defined:
  - Adds output `drop_cnt` [7:0], reset 0, which counts dropped records and saturates at 255.
  - `drop` behaves as specified above.
- Undefined: the `drop_cnt` port and counter logic are absent; only the sticky `drop` flag remains.

## Structure

- **Shared package `div_pkg`:**
  - `div_status_t` enum (`OK`, `DIV0`, `OVF`).
  - `div_rec_t` packed struct {quot, rem, status}.
  - Default widths `DIV_QW` / `DIV_RW` = 5.
  - Collector FSM state enum.
- **Sub-module `div_result_fifo`:** parameterised synchronous FIFO of `div_rec_t`.
  - Ports: push/pop, full/empty, head.
  - Drop-on-full handling stays in the collector, not in this module.

## Test plan

- 100÷7: quotient 14 on `doneq`, then remainder 2 on `donew` two cycles later → one record {14, 2, OK}; `res_valid` high the cycle after `donew`.
- `div_by0` pulse while in WAIT_R with quotient 9 latched → record {0, 0, DIV0}; quotient 9 never appears; `proto_err`=0.
- `ov` and `div_by0` in the same cycle → single record with status DIV0.
- Five OK results with `res_ready`=0 and DEPTH=4 → four records kept in order, fifth dropped, `drop`=1, `drop_cnt`=1 (macro on). Then assert `res_ready` → records drain in order.
- FIFO full, with `res_ready`=1 and `donew` completing in the same cycle → pop and push both occur; `fifo_full` stays 1; `drop`=0.
- `donew` in IDLE, then `rst`=0 for one edge → `proto_err` goes 1, then back to 0; FIFO empty; `res_valid`=0.
